// File: rtl/nexus_nonce_sweeper.sv
// rtl/nexus_nonce_sweeper.sv - SK1024 nonce-sweep controller with in-flight tracking, hit filter and result FIFO
// Optional macro NXS_FULL_TARGET_EN adds an unsigned HashQword <= TargetQword test to the hit rule.
module nexus_nonce_sweeper #(
  parameter int PIPE_LATENCY = 390,
  parameter int HASHERS      = 1,
  parameter int COREIDX      = 0,
  parameter int ZERO_BITS    = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        HashRst,
  input  logic        WorkLoad,
  input  logic [63:0] StartNonce,
  input  logic [63:0] EndNonce,
  input  logic [63:0] TargetQword,
  output logic [63:0] PipeNonce,
  output logic        PipeValid,
  input  logic [63:0] HashQword,
  output logic [63:0] ResultNonce,
  output logic        ResultValid,
  input  logic        ResultReady,
  output logic        Busy,
  output logic        Done,
  output logic [15:0] DropCount
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [63:0]             r_end;
  logic [63:0]             r_pipe_nonce;
  logic [63:0]             r_out_nonce;
  logic [PIPE_LATENCY-1:0] r_vld_sr;
  logic [63:0]             r_mem [FIFO_DEPTH];
  logic [AW:0]             r_wr_ptr;
  logic [AW:0]             r_rd_ptr;
  logic [15:0]             r_drop;

  logic [64:0] w_first;
  logic        w_first_bad;
  logic [64:0] w_step;
  logic        w_last;
  logic        w_out_valid;
  logic        w_sr_next_zero;
  logic        w_lz_ok;
  logic        w_hit;
  logic        w_empty;
  logic        w_full;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;

  // 65-bit sums so that a carry out of bit 63 ends the range instead of wrapping
  assign w_first     = {1'b0, StartNonce} + 65'(COREIDX);
  assign w_first_bad = w_first[64] | (w_first[63:0] > EndNonce);
  assign w_step      = {1'b0, r_pipe_nonce} + 65'(HASHERS);
  assign w_last      = w_step[64] | (w_step[63:0] > r_end);

  assign w_out_valid    = r_vld_sr[PIPE_LATENCY-1];
  assign w_sr_next_zero = (r_vld_sr[PIPE_LATENCY-2:0] == '0);
  assign w_lz_ok        = (HashQword[63 -: ZERO_BITS] == '0);

`ifdef NXS_FULL_TARGET_EN
  logic [63:0] r_target;

  always_ff @(posedge clk or posedge HashRst) begin
    if (HashRst) begin
      r_target <= '0;
    end else if (WorkLoad) begin
      r_target <= TargetQword;
    end
  end

  assign w_hit = w_out_valid & w_lz_ok & (HashQword <= r_target);
`else
  logic w_unused_inputs;
  assign w_unused_inputs = ^{HashQword, TargetQword};
  assign w_hit = w_out_valid & w_lz_ok;
`endif

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & ResultReady;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the hit
  assign w_push  = w_hit & (~w_full | w_pop);
  assign w_drop  = w_hit & w_full & ~w_pop;

  always_comb begin
    w_state_nxt = r_state;
    PipeValid   = 1'b0;
    Busy        = 1'b0;
    Done        = 1'b0;
    case (r_state)
      S_SWEEP: begin
        PipeValid = 1'b1;
        Busy      = 1'b1;
        if (w_last) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        Busy = 1'b1;
        if (w_sr_next_zero) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        Done = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (WorkLoad) begin
      w_state_nxt = w_first_bad ? S_DRAIN : S_SWEEP;
    end
  end

  always_ff @(posedge clk or posedge HashRst) begin
    if (HashRst) begin
      r_state      <= S_IDLE;
      r_end        <= '0;
      r_pipe_nonce <= '0;
      r_out_nonce  <= '0;
      r_vld_sr     <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_drop       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (WorkLoad) begin
        // restart discards everything in flight and anything still queued
        r_end        <= EndNonce;
        r_pipe_nonce <= w_first[63:0];
        r_out_nonce  <= w_first[63:0];
        r_vld_sr     <= '0;
        r_wr_ptr     <= '0;
        r_rd_ptr     <= '0;
        r_drop       <= '0;
      end else begin
        r_vld_sr <= {r_vld_sr[PIPE_LATENCY-2:0], PipeValid};
        if (PipeValid && !w_last) begin
          r_pipe_nonce <= w_step[63:0];
        end
        if (w_out_valid) begin
          r_out_nonce <= r_out_nonce + 64'(HASHERS);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
        end
        if (w_drop && (r_drop != 16'hFFFF)) begin
          r_drop <= r_drop + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !WorkLoad) begin
      r_mem[r_wr_ptr[AW-1:0]] <= r_out_nonce;
    end
  end

  assign PipeNonce   = r_pipe_nonce;
  assign ResultValid = ~w_empty;
  assign ResultNonce = w_empty ? 64'h0 : r_mem[r_rd_ptr[AW-1:0]];
  assign DropCount   = r_drop;

endmodule

// File: doc/nexus_nonce_sweeper.md
# nexus_nonce_sweeper

Parametrised nonce-sweep controller for the SK1024 hash pipeline. Issues one nonce per cycle over a bounded range [StartNonce, EndNonce] with per-core stride and offset. Tracks in-flight valid bits across a configurable pipeline latency and recovers each result's nonce with an output-side counter. Filters hash results against a target and queues hits in a result FIFO with ready/valid handshake; the range-end, drain and done semantics extend the free-running per-core sweeper.

## Interface
Parameters:
- PIPE_LATENCY, 390: cycles from PipeValid/PipeNonce issue to matching HashQword; ≥ 2
- HASHERS, 1: nonce stride (core count)
- COREIDX, 0: nonce offset of this core; < HASHERS
- ZERO_BITS, 32: required leading zero bits of HashQword; 1..64
- FIFO_DEPTH, 4: result FIFO entries; power of 2, ≥ 2

Ports:
- clk  in  1  single clock, rising edge
- HashRst  in  1  asynchronous, active-high reset
- WorkLoad  in  1  one-cycle pulse: latch range and target, start sweep
- StartNonce  in  64  first nonce base (COREIDX added)
- EndNonce  in  64  inclusive last nonce allowed
- TargetQword  in  64  full target (used only with NXS_FULL_TARGET_EN)
- PipeNonce  out  64  nonce issued to hash pipeline
- PipeValid  out  1  PipeNonce valid this cycle
- HashQword  in  64  pipeline result qword, PIPE_LATENCY cycles after issue
- ResultNonce  out  64  FIFO head nonce
- ResultValid  out  1  FIFO non-empty
- ResultReady  in  1  consumer pops head when ResultValid & ResultReady
- Busy  out  1  state SWEEP or DRAIN
- Done  out  1  state DONE
- DropCount  out  16  hits lost to full FIFO, saturating

## Operation
- States: IDLE, SWEEP, DRAIN, DONE.
- IDLE/any state + WorkLoad: latch range/target; clear valid shift register, FIFO, DropCount; PipeNonce ← StartNonce+COREIDX; OutNonce ← same. Enter SWEEP, or DRAIN if StartNonce+COREIDX > EndNonce or that sum overflows 64 bits.
- SWEEP: PipeValid=1 each cycle; after issuing n, if n+HASHERS > EndNonce or carries out of bit 63 → DRAIN (n is the last nonce issued); else PipeNonce ← n+HASHERS.
- DRAIN: PipeValid=0; when valid shift register is all zero → DONE.
- DONE: Done=1 until WorkLoad (restart) or reset.
- Valid tracking: PIPE_LATENCY-bit shift register, input PipeValid; tap OutValid = bit PIPE_LATENCY-1.
- Nonce recovery: on each OutValid cycle, the result belongs to OutNonce; OutNonce ← OutNonce+HASHERS (64-bit wrap).
- Hit: OutValid & HashQword[63:64-ZERO_BITS]==0 (plus target rule below).
- FIFO: hit pushes OutNonce. Full with no pop: drop, DropCount+1 (saturate 0xFFFF). Full with simultaneous pop: push accepted, no drop. Empty: no pop.
- HashRst asserted: state IDLE; PipeNonce, OutNonce, shift register, FIFO pointers, DropCount cleared; all outputs 0.

## Timing
- WorkLoad at cycle t → PipeValid=1, PipeNonce=StartNonce+COREIDX at t+1.
- Issue at cycle c → HashQword sampled at c+PIPE_LATENCY; hit visible at ResultValid/ResultNonce at c+PIPE_LATENCY+1 (FIFO previously empty).
- Pop at edge ending cycle k → next head (or ResultValid=0) at k+1.
- Last issue at cycle e → Done=1 at e+PIPE_LATENCY+1; Busy falls same cycle.
- WorkLoad during SWEEP/DRAIN: in-flight results discarded, never pushed.
- Throughput: one nonce/cycle in SWEEP, no stalls; FIFO backpressure never stops the sweep.

## Configuration
- NXS_FULL_TARGET_EN defined: hit additionally requires HashQword ≤ TargetQword (unsigned 64-bit), TargetQword latched on WorkLoad.
- Undefined: leading-zero check only; TargetQword ignored, no comparator synthesised.

## Test plan
- PIPE_LATENCY=8, HASHERS=1: StartNonce=100, EndNonce=103, HashQword=0 always -> PipeValid 4 cycles (100..103); ResultNonce 100,101,102,103 with ResultReady=1; Done 9 cycles after last issue.
- HASHERS=4, COREIDX=2: Start=0, End=13 -> issued 2,6,10; End=0xFFFF_FFFF_FFFF_FFFE, Start=0xFFFF_FFFF_FFFF_FFF8 -> issued ...FFFA, ...FFFE, no wrap.
- FIFO_DEPTH=4, ResultReady=0, 6 consecutive hits -> 4 queued in order, DropCount=2; pop while full plus hit -> no drop.
- ZERO_BITS=32: HashQword=0x0000_0000_FFFF_FFFF -> hit; 0x0000_0001_0000_0000 -> none. With NXS_FULL_TARGET_EN, Target=0x0000_0000_0000_1000: 0x...0FFF hit, 0x...1001 none.
- WorkLoad mid-SWEEP with 5 hits in flight -> none appear, FIFO empty, new range starts next cycle.
- HashRst pulse mid-DRAIN -> all outputs 0 immediately; state IDLE; no results after release.
